// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, single-outstanding imem FSM and IF/ID output latch.
// Optional fetch counter enabled by defining INSTR_FETCH_PERF_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_incr_o,
    output logic        valid_o,
    output logic [31:0] fetch_count_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        discard_q;
    logic        discard_d;
    logic [31:0] hold_instr_q;
    logic [31:0] hold_instr_d;
    logic [31:0] hold_pc_q;
    logic [31:0] hold_pc_d;
    logic [31:0] instr_d;
    logic [31:0] pc_incr_d;
    logic        valid_d;
    logic        out_stall;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_tgt;

    assign out_stall    = stall_i && valid_o;
    assign pc_plus4     = pc_q + 32'd4;
    assign redirect_tgt = redirect_pc_i & ~32'h0000_0003;
    assign imem_addr_o  = pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        discard_d    = discard_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        instr_d      = instr_o;
        pc_incr_d    = pc_incr_o;
        valid_d      = valid_o;
        imem_req_o   = 1'b0;

        if (redirect_i) begin
            instr_d      = NOP;
            valid_d      = 1'b0;
            hold_instr_d = '0;
            hold_pc_d    = '0;
            pc_d         = redirect_tgt;
            // A response still in flight must be swallowed when it lands
            if (state_q == WAIT && !imem_rvalid_i) begin
                state_d   = WAIT;
                discard_d = 1'b1;
            end else begin
                state_d   = ISSUE;
                discard_d = 1'b0;
            end
        end else begin
            if (!stall_i) begin
                instr_d = NOP;
                valid_d = 1'b0;
            end
            unique case (state_q)
                ISSUE: begin
                    if (!out_stall) begin
                        imem_req_o = 1'b1;
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        state_d = ISSUE;
                        if (discard_q) begin
                            discard_d = 1'b0;
                        end else if (out_stall) begin
                            hold_instr_d = imem_rdata_i;
                            hold_pc_d    = pc_plus4;
                            pc_d         = pc_plus4;
                            state_d      = HOLD;
                        end else begin
                            instr_d   = imem_rdata_i;
                            pc_incr_d = pc_plus4;
                            valid_d   = 1'b1;
                            pc_d      = pc_plus4;
                        end
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        instr_d   = hold_instr_q;
                        pc_incr_d = hold_pc_q;
                        valid_d   = 1'b1;
                        state_d   = ISSUE;
                    end
                end
                default: begin
                    state_d = ISSUE;
                end
            endcase
        end

        if (rst) begin
            imem_req_o = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ISSUE;
            pc_q         <= RESET_PC;
            discard_q    <= 1'b0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            instr_o      <= NOP;
            pc_incr_o    <= '0;
            valid_o      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            discard_q    <= discard_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            instr_o      <= instr_d;
            pc_incr_o    <= pc_incr_d;
            valid_o      <= valid_d;
        end
    end

`ifdef INSTR_FETCH_PERF_EN
    logic        capture;
    logic [31:0] count_q;

    // Counts only data that reaches the outputs or the hold buffer
    assign capture = !redirect_i && (state_q == WAIT)
                  && imem_rvalid_i && !discard_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (capture) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign fetch_count_o = count_q;
`else
    assign fetch_count_o = '0;
`endif

endmodule
